// File: rtl/button_conditioner.sv
// Button front-end for the multiplexed-display clock: synchronises and
// debounces the prog and adjust buttons, owns the programming mode register,
// generates adjust ticks with hold-to-auto-repeat and returns to run mode
// after a period of inactivity.
module button_conditioner #(
  parameter int unsigned DEB_TICKS    = 20,
  parameter int unsigned HOLD_TICKS   = 2000,
  parameter int unsigned REPEAT_TICKS = 400,
  parameter int unsigned IDLE_TICKS   = 60000
) (
  input  logic       clk_500u,
  input  logic       rst,
  input  logic       prog_raw,
  input  logic       adjust_raw,
  output logic [1:0] mode,
  output logic       adjust_tick,
  output logic       prog_level,
  output logic       adjust_level,
  output logic       timeout_pulse
);

  localparam int unsigned DebW   = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam int unsigned RepMax = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int unsigned RcntW  = (RepMax > 1) ? $clog2(RepMax) : 1;

  localparam logic [DebW-1:0]  DebLast  = DebW'(DEB_TICKS - 1);
  localparam logic [RcntW-1:0] HoldLast = RcntW'(HOLD_TICKS - 1);
  localparam logic [RcntW-1:0] RepLast  = RcntW'(REPEAT_TICKS - 1);
  localparam logic [15:0]      IdleLast = 16'(IDLE_TICKS - 1);

  typedef enum logic [1:0] {
    AIdle = 2'd0,
    AHold = 2'd1,
    ARep  = 2'd2
  } adj_state_e;

  // Synchroniser chains; bit 1 is the settled sample.
  logic [1:0] prog_sync_q, adj_sync_q;
  logic       prog_sync2, adj_sync2;

  // Debounce state per channel.
  logic [DebW-1:0] prog_cnt_q, prog_cnt_d;
  logic [DebW-1:0] adj_cnt_q, adj_cnt_d;
  logic            prog_lvl_q, prog_lvl_d;
  logic            adj_lvl_q, adj_lvl_d;
  logic            prog_press, adj_press;

  // Adjust auto-repeat FSM.
  adj_state_e       state_q, state_d;
  logic [RcntW-1:0] rcnt_q, rcnt_d;
  logic             adj_evt;

  // Mode register and idle timeout.
  logic [1:0]  mode_q, mode_d;
  logic [15:0] icnt_q, icnt_d;
  logic        timeout_q, timeout_d;

  // Tick pipeline: arm is gated by the mode seen on the event edge, so a
  // same-edge prog press cannot change whether the tick fires.
  logic tick_arm_q, tick_arm_d;
  logic tick_q;

  assign prog_sync2 = prog_sync_q[1];
  assign adj_sync2  = adj_sync_q[1];

  // Two-flop synchronisers for the asynchronous raw buttons
  always_ff @(posedge clk_500u or negedge rst) begin
    if (!rst) begin
      prog_sync_q <= 2'b00;
      adj_sync_q  <= 2'b00;
    end else begin
      prog_sync_q <= {prog_sync_q[0], prog_raw};
      adj_sync_q  <= {adj_sync_q[0], adjust_raw};
    end
  end

  // Debounce next-state: accept a new level after DEB_TICKS disagreeing edges
  always_comb begin
    prog_cnt_d = '0;
    prog_lvl_d = prog_lvl_q;
    prog_press = 1'b0;
    if (prog_sync2 != prog_lvl_q) begin
      if (prog_cnt_q == DebLast) begin
        prog_lvl_d = prog_sync2;
        prog_press = prog_sync2;
      end else begin
        prog_cnt_d = prog_cnt_q + DebW'(1);
      end
    end

    adj_cnt_d = '0;
    adj_lvl_d = adj_lvl_q;
    adj_press = 1'b0;
    if (adj_sync2 != adj_lvl_q) begin
      if (adj_cnt_q == DebLast) begin
        adj_lvl_d = adj_sync2;
        adj_press = adj_sync2;
      end else begin
        adj_cnt_d = adj_cnt_q + DebW'(1);
      end
    end
  end

  // Debounce counters and accepted levels
  always_ff @(posedge clk_500u or negedge rst) begin
    if (!rst) begin
      prog_cnt_q <= '0;
      adj_cnt_q  <= '0;
      prog_lvl_q <= 1'b0;
      adj_lvl_q  <= 1'b0;
    end else begin
      prog_cnt_q <= prog_cnt_d;
      adj_cnt_q  <= adj_cnt_d;
      prog_lvl_q <= prog_lvl_d;
      adj_lvl_q  <= adj_lvl_d;
    end
  end

  // Adjust FSM next-state: event on press, after the hold delay, then periodically
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    adj_evt = 1'b0;
    unique case (state_q)
      AIdle: begin
        if (adj_press) begin
          adj_evt = 1'b1;
          state_d = AHold;
          rcnt_d  = '0;
        end
      end
      AHold: begin
        if (!adj_lvl_q) begin
          state_d = AIdle;
          rcnt_d  = '0;
        end else if (rcnt_q == HoldLast) begin
          adj_evt = 1'b1;
          state_d = ARep;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + RcntW'(1);
        end
      end
      ARep: begin
        if (!adj_lvl_q) begin
          state_d = AIdle;
          rcnt_d  = '0;
        end else if (rcnt_q == RepLast) begin
          adj_evt = 1'b1;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + RcntW'(1);
        end
      end
      default: begin
        state_d = AIdle;
        rcnt_d  = '0;
      end
    endcase
  end

  // Adjust FSM state register
  always_ff @(posedge clk_500u or negedge rst) begin
    if (!rst) begin
      state_q <= AIdle;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Mode stepping and idle timeout; a prog press beats a same-edge timeout
  always_comb begin
    mode_d     = mode_q;
    icnt_d     = icnt_q;
    timeout_d  = 1'b0;
    tick_arm_d = adj_evt && (mode_q != 2'd0);
    if (prog_press) begin
      mode_d = mode_q + 2'd1;
      icnt_d = '0;
    end else if (adj_evt || (mode_q == 2'd0)) begin
      icnt_d = '0;
    end else if (icnt_q == IdleLast) begin
      mode_d    = 2'd0;
      timeout_d = 1'b1;
      icnt_d    = '0;
    end else begin
      icnt_d = icnt_q + 16'd1;
    end
  end

  // Mode, idle counter and output pulse registers
  always_ff @(posedge clk_500u or negedge rst) begin
    if (!rst) begin
      mode_q     <= 2'd0;
      icnt_q     <= '0;
      timeout_q  <= 1'b0;
      tick_arm_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      icnt_q     <= icnt_d;
      timeout_q  <= timeout_d;
      tick_arm_q <= tick_arm_d;
      tick_q     <= tick_arm_q;
    end
  end

  assign mode          = mode_q;
  assign adjust_tick   = tick_q;
  assign prog_level    = prog_lvl_q;
  assign adjust_level  = adj_lvl_q;
  assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner. Each scenario is a raw waveform per
// button (value sampled at each edge after reset release); a reference model
// turns it into a time-ordered list of expected output events, and a monitor
// compares every observed output change against that list.
`timescale 1us/1ns
module tb_button_conditioner;

  localparam int Deb  = 20;
  localparam int Hold = 2000;
  localparam int Rep  = 400;
  localparam int Idle = 4000;
  localparam int MaxN = 8192;

  logic       clk_500u   = 1'b0;
  logic       rst        = 1'b0;
  logic       prog_raw   = 1'b0;
  logic       adjust_raw = 1'b0;
  logic [1:0] mode;
  logic       adjust_tick;
  logic       prog_level;
  logic       adjust_level;
  logic       timeout_pulse;

  button_conditioner #(
    .DEB_TICKS   (Deb),
    .HOLD_TICKS  (Hold),
    .REPEAT_TICKS(Rep),
    .IDLE_TICKS  (Idle)
  ) dut (
    .clk_500u     (clk_500u),
    .rst          (rst),
    .prog_raw     (prog_raw),
    .adjust_raw   (adjust_raw),
    .mode         (mode),
    .adjust_tick  (adjust_tick),
    .prog_level   (prog_level),
    .adjust_level (adjust_level),
    .timeout_pulse(timeout_pulse)
  );

  always #250 clk_500u = ~clk_500u;

  // kind: 0 mode, 1 prog_level, 2 adjust_level, 3 adjust_tick, 4 timeout_pulse
  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  ev_t   exp_q[$];
  int    n_tests  = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    base_cyc = 0;
  bit    mon_en   = 1'b0;
  string cur_name = "";

  bit prog_w[MaxN+2];
  bit adj_w[MaxN+2];
  bit lvl_p[MaxN+2];
  bit lvl_a[MaxN+2];

  function automatic string kind_name(input int k);
    case (k)
      0:       return "mode";
      1:       return "prog_level";
      2:       return "adjust_level";
      3:       return "adjust_tick";
      default: return "timeout_pulse";
    endcase
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_mode"}, int'(mode), 0);
    check({name, "_adjust_tick"}, int'(adjust_tick), 0);
    check({name, "_prog_level"}, int'(prog_level), 0);
    check({name, "_adjust_level"}, int'(adjust_level), 0);
    check({name, "_timeout_pulse"}, int'(timeout_pulse), 0);
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_unexpected: got %s=%0d at edge %0d, required no event", cur_name,
               kind_name(kind), val, cyc - base_cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.kind != kind || e.val != val) begin
        n_fail++;
        $display("FAIL %s_event: got %s=%0d at edge %0d, required %s=%0d at edge %0d",
                 cur_name, kind_name(kind), val, cyc - base_cyc, kind_name(e.kind), e.val,
                 e.cyc - base_cyc);
      end
    end
  endtask

  // Monitor: every output change (or pulse) after each edge is one observation.
  initial begin : monitor
    logic [1:0] pm;
    logic       pp;
    logic       pa;
    pm = 2'd0;
    pp = 1'b0;
    pa = 1'b0;
    forever begin
      @(posedge clk_500u);
      cyc++;
      #1;
      if (mon_en) begin
        if (mode != pm)          observe(0, int'(mode));
        if (prog_level != pp)    observe(1, int'(prog_level));
        if (adjust_level != pa)  observe(2, int'(adjust_level));
        if (adjust_tick)         observe(3, 1);
        if (timeout_pulse)       observe(4, 1);
      end
      pm = mode;
      pp = prog_level;
      pa = adjust_level;
    end
  end

  // A level flips once the input seen by the debouncer (the raw sample from two
  // edges earlier) has disagreed with it on Deb consecutive edges.
  function automatic void debounce(input int n, input bit ch);
    bit lvl;
    int run;
    bit s;
    lvl = 1'b0;
    run = 0;
    if (ch) lvl_a[0] = 1'b0;
    else    lvl_p[0] = 1'b0;
    for (int k = 1; k <= n; k++) begin
      if (k >= 3) s = ch ? adj_w[k-2] : prog_w[k-2];
      else        s = 1'b0;
      if (s != lvl) begin
        run++;
        if (run == Deb) begin
          lvl = s;
          run = 0;
        end
      end else begin
        run = 0;
      end
      if (ch) lvl_a[k] = lvl;
      else    lvl_p[k] = lvl;
    end
  endfunction

  task automatic push(input int c, input int kind, input int val);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Expected events for edges 1..n: press-driven mode steps, adjust events on
  // the press / hold / repeat schedule, ticks one edge later when the mode was
  // non-zero, and a timeout Idle edges after the last press or adjust event.
  task automatic build_expected(input int n, input int base);
    int m, nm, last, pa, d;
    bit pend, pp, ev, to;
    m    = 0;
    last = 0;
    pa   = -1;
    pend = 1'b0;
    debounce(n, 1'b0);
    debounce(n, 1'b1);
    for (int k = 1; k <= n; k++) begin
      pp = lvl_p[k] && !lvl_p[k-1];
      ev = 1'b0;
      if (lvl_a[k] && !lvl_a[k-1]) begin
        ev = 1'b1;
        pa = k;
      end else if (lvl_a[k-1] && pa >= 0) begin
        d = k - pa;
        if (d == Hold || (d > Hold && (d - Hold) % Rep == 0)) ev = 1'b1;
      end
      to = 1'b0;
      if (pp || ev)                         last = k;
      else if (m != 0 && k - last == Idle)  to = 1'b1;
      nm = pp ? (m + 1) % 4 : (to ? 0 : m);
      if (nm != m)              push(base + k, 0, nm);
      if (lvl_p[k] != lvl_p[k-1]) push(base + k, 1, int'(lvl_p[k]));
      if (lvl_a[k] != lvl_a[k-1]) push(base + k, 2, int'(lvl_a[k]));
      if (pend)                 push(base + k, 3, 1);
      if (to)                   push(base + k, 4, 1);
      pend = ev && (m != 0);
      m    = nm;
    end
  endtask

  task automatic clear_w();
    for (int k = 0; k < MaxN + 2; k++) begin
      prog_w[k] = 1'b0;
      adj_w[k]  = 1'b0;
    end
  endtask

  task automatic set_w(input bit ch, input int from, input int upto, input bit v);
    for (int k = from; k <= upto; k++) begin
      if (ch) adj_w[k] = v;
      else    prog_w[k] = v;
    end
  endtask

  task automatic rand_w(input bit ch, input int n);
    int k, len, hi;
    bit v;
    k = 1;
    v = 1'b0;
    while (k <= n) begin
      case ($urandom_range(0, 3))
        0:       len = $urandom_range(1, Deb - 1);
        1:       len = $urandom_range(Deb - 2, Deb + 2);
        2:       len = $urandom_range(Deb, 300);
        default: len = $urandom_range(300, 2600);
      endcase
      hi = (k + len - 1 > n) ? n : k + len - 1;
      set_w(ch, k, hi, v);
      k = k + len;
      v = ~v;
    end
  endtask

  // Reset (raw held at the first sample), then play n edges of waveform.
  task automatic run_scenario(input int n, input string name);
    ev_t e;
    rst        = 1'b0;
    mon_en     = 1'b0;
    prog_raw   = prog_w[1];
    adjust_raw = adj_w[1];
    repeat (3) @(negedge clk_500u);
    check_zero({name, "_in_reset"});
    cur_name = name;
    base_cyc = cyc;
    build_expected(n, cyc);
    rst    = 1'b1;
    mon_en = 1'b1;
    #1;
    check_zero({name, "_after_release"});
    for (int k = 2; k <= n; k++) begin
      @(negedge clk_500u);
      prog_raw   = prog_w[k];
      adjust_raw = adj_w[k];
    end
    @(negedge clk_500u);
    mon_en = 1'b0;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      e = exp_q[0];
      $display("FAIL %s_missing: got %0d events unseen, required 0 (first %s=%0d at edge %0d)",
               name, exp_q.size(), kind_name(e.kind), e.val, e.cyc - base_cyc);
      exp_q.delete();
    end
  endtask

  initial begin : stimulus
    clear_w();
    set_w(0, 1, 60, 1'b1);
    set_w(1, 1, 60, 1'b1);
    run_scenario(60, "reset_held");

    clear_w();
    set_w(0, 10, 28, 1'b1);
    run_scenario(100, "pulse_19");

    clear_w();
    set_w(0, 10, 29, 1'b1);
    run_scenario(100, "pulse_20");

    clear_w();
    for (int k = 10; k < 70; k += 10) set_w(0, k, k + 4, 1'b1);
    set_w(0, 70, 220, 1'b1);
    run_scenario(220, "bounce");

    clear_w();
    for (int i = 0; i < 4; i++) set_w(0, 10 + 200 * i, 59 + 200 * i, 1'b1);
    run_scenario(900, "mode_cycle");

    clear_w();
    set_w(1, 10, 3009, 1'b1);
    run_scenario(3100, "adjust_mode0");

    clear_w();
    set_w(0, 10, 49, 1'b1);
    set_w(0, 210, 249, 1'b1);
    set_w(1, 400, 3420, 1'b1);
    run_scenario(3500, "auto_repeat");

    clear_w();
    set_w(0, 10, 49, 1'b1);
    set_w(0, 210, 249, 1'b1);
    set_w(1, 400, 1900, 1'b1);
    run_scenario(2000, "early_release");

    clear_w();
    set_w(0, 10, 49, 1'b1);
    run_scenario(4100, "timeout");

    clear_w();
    set_w(0, 10, 49, 1'b1);
    set_w(1, 4000, 4099, 1'b1);
    run_scenario(4100, "timeout_restart");

    clear_w();
    set_w(0, 10, 49, 1'b1);
    set_w(0, 4010, 4049, 1'b1);
    run_scenario(4100, "collision");

    for (int r = 0; r < 4; r++) begin
      clear_w();
      rand_w(1'b0, (r == 3) ? 7000 : 3000);
      rand_w(1'b1, (r == 3) ? 7000 : 3000);
      run_scenario((r == 3) ? 7000 : 3000, $sformatf("random%0d", r));
    end

    // Stop on the edge the third tick appears, then reset asynchronously.
    clear_w();
    set_w(0, 1, 40, 1'b1);
    set_w(1, 50, 3000, 1'b1);
    run_scenario(2472, "pre_reset_repeat");
    check("tick_before_reset", int'(adjust_tick), 1);
    check("mode_before_reset", int'(mode), 1);
    rst = 1'b0;
    #1;
    check_zero("reset_mid_repeat");
    repeat (2) @(negedge clk_500u);
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end for the two user buttons (prog, adjust) of the multiplexed-display clock.
- Synchronises and debounces each raw button on the 2 kHz clk_500u tick.
- Owns the 2-bit programming mode register (0 = run, 1 = set seconds, 2 = set minutes, 3 = set hours).
- Emits clean single-cycle adjust ticks with hold-to-auto-repeat. A mode-return timeout brings the clock back to run mode. Downstream, the time-keeping register consumes mode and adjust_tick.

Parameters:
- DEB_TICKS, 20, consecutive clk_500u cycles of changed input required to accept a new level (10 ms).
- HOLD_TICKS, 2000, cycles adjust must stay held after its press before auto-repeat starts (1 s).
- REPEAT_TICKS, 400, auto-repeat period once repeating (200 ms).
- IDLE_TICKS, 60000, cycles without any accepted press before a non-zero mode returns to 0 (30 s).

Ports:
- clk_500u, input, 1, 2 kHz tick clock.
- rst, input, 1, asynchronous active-low reset.
- prog_raw, input, 1, raw prog button (active high, bouncy, asynchronous).
- adjust_raw, input, 1, raw adjust button (active high, bouncy, asynchronous).
- mode, output, 2, current programming mode.
- adjust_tick, output, 1, one-cycle increment request; only asserted when mode != 0.
- prog_level, output, 1, debounced prog level.
- adjust_level, output, 1, debounced adjust level.
- timeout_pulse, output, 1, one-cycle flag on automatic return to mode 0.

Behaviour:
- Reset: rst=0 asynchronously clears all sync flops, debounce counters, levels, mode, FSM (A_IDLE), idle counter and all outputs to 0. Reset mid-hold or mid-debounce discards progress. No pulse is emitted on release of rst even if a button is held; the press is accepted normally DEB_TICKS+2 edges later.
- Synchroniser: two flops per button. Edge n is the first edge sampling raw=1; sync2 is 1 after edge n+1.
- Debounce, per channel:
  - cnt increments each edge where sync2 != level, and clears to 0 when equal.
  - At an edge where sync2 != level and cnt == DEB_TICKS-1: level <= sync2, cnt <= 0.
  - A clean press is therefore accepted at edge n+DEB_TICKS+1. A raw high lasting DEB_TICKS cycles is accepted; DEB_TICKS-1 cycles is rejected. Release uses the identical rule.
- Press events: prog_press / adj_press are internal one-cycle strobes asserted on the same edge the level goes 0->1. No event on release.
- Mode: on prog_press, mode <= mode+1, wrapping 3->0.
- Adjust FSM (A_IDLE, A_HOLD, A_REP; rcnt sized by $clog2(max(HOLD_TICKS,REPEAT_TICKS))):
  - A_IDLE: on adj_press, emit event and go to A_HOLD with rcnt=0.
  - A_HOLD: if adjust_level=0, go to A_IDLE with no event. Else if rcnt == HOLD_TICKS-1, emit event and go to A_REP with rcnt=0. Else rcnt++.
  - A_REP: if adjust_level=0, go to A_IDLE. Else if rcnt == REPEAT_TICKS-1, emit event and set rcnt=0. Else rcnt++.
  - Event timing: press at edge p gives events at p, p+HOLD_TICKS, then every REPEAT_TICKS.
- adjust_tick = registered (FSM event AND mode != 0), using mode before any same-edge update. It is high for exactly one cycle and appears one edge after the event. The FSM runs in mode 0 but its ticks are suppressed there.
- Idle timeout:
  - 16-bit icnt counts while mode != 0. It clears on any prog_press, FSM event, or while mode == 0.
  - When icnt == IDLE_TICKS-1: mode <= 0, timeout_pulse=1 for one cycle, icnt <= 0.
  - A prog_press on the same edge wins: mode increments, icnt clears, no timeout_pulse.
- Simultaneous prog_press and adjust event: both are honoured. The tick is gated by the old mode.
- No combinational path from raw inputs to any output.

Test Plan:
- Reset: hold both raw at 1 during rst=0, then release -> all outputs 0. prog_level rises exactly 22 edges after release; mode=1 at that edge. Assert rst mid-A_REP -> mode=0, adjust_tick=0 immediately.
- Debounce: prog_raw high 19 cycles, then 0 -> no level change, mode stays 0. High 20 cycles -> mode=1. Bounce with 5-cycle toggles for 60 cycles, then steady 1 -> exactly one increment.
- Mode cycling: four clean presses, 200 cycles apart -> mode sequence 1,2,3,0. Adjust held in mode 0 for 3000 cycles -> zero adjust_tick.
- Auto-repeat: mode=2, adjust held 3000 cycles after acceptance at edge p -> adjust_tick at p+1, p+2001, p+2401, p+2801 (4 ticks). Release at p+1500 -> exactly 1 tick.
- Timeout: mode=1, no input -> at edge IDLE_TICKS after the press, mode=0 and timeout_pulse high 1 cycle. An adjust tick at 59990 cycles restarts the count, so mode is still 1 at 60010.
- Collision: prog press accepted on the same edge icnt hits 59999 -> mode advances to 2, timeout_pulse stays 0.
